// File: rtl/stream_burst_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_burst_arb_pkg                                       |
// | Description : Shared state encoding and sizing helper for the arbiter.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package stream_burst_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_burst_arb_rr_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_burst_arb_rr_sel                                    |
// | Description : Rotate-priority selector: first valid at or above pointer. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stream_burst_arb_rr_sel
    import stream_burst_arb_pkg::*;
#(
    parameter int NUM_INP = 4,
    parameter int IDX_W   = idx_width(NUM_INP)
) (
    input  logic [NUM_INP-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_sel,
    output logic               o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_sel  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < NUM_INP; k++) begin
            // Wrap explicitly so non-power-of-2 counts never produce an index >= NUM_INP.
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_INP)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_INP);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_any && i_valid[w_cand]) begin
                o_any = 1'b1;
                o_sel = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_burst_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_burst_arbiter                                       |
// | Description : Round-robin burst arbiter, grant held until last/beat cap. |
// |               STREAM_BURST_ARB_TIMEOUT_EN adds a sticky stall timeout.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stream_burst_arbiter
    import stream_burst_arb_pkg::*;
#(
    parameter  int NUM_INP        = 4,
    parameter  int DATA_WIDTH     = 32,
    parameter  int MAX_BEATS      = 16,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int c_idx_w        = idx_width(NUM_INP)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [NUM_INP-1:0][DATA_WIDTH-1:0] inp_data_i,
    input  logic [NUM_INP-1:0]                 inp_last_i,
    input  logic [NUM_INP-1:0]                 inp_valid_i,
    output logic [NUM_INP-1:0]                 inp_ready_o,
    output logic [DATA_WIDTH-1:0]              oup_data_o,
    output logic                               oup_last_o,
    output logic                               oup_valid_o,
    input  logic                               oup_ready_i,
    output logic [c_idx_w-1:0]                 oup_idx_o,
    output logic                               busy_o
`ifdef STREAM_BURST_ARB_TIMEOUT_EN
    ,
    output logic                               timeout_o
`endif
);

    localparam int                 c_cnt_w = $clog2(MAX_BEATS + 1);
    localparam logic [c_cnt_w-1:0] c_cap   = c_cnt_w'(MAX_BEATS - 1);

    arb_state_e         r_state;
    logic [c_idx_w-1:0] r_rr_ptr;
    logic [c_idx_w-1:0] r_lock_idx;
    logic [c_cnt_w-1:0] r_beat_cnt;

    logic [c_idx_w-1:0] w_sel;
    logic [c_idx_w-1:0] w_idx;
    logic               w_any;
    logic               w_valid;
    logic               w_end;
    logic               w_hs;

    function automatic logic [c_idx_w-1:0] next_idx(input logic [c_idx_w-1:0] idx);
        return (idx == c_idx_w'(NUM_INP - 1)) ? '0 : idx + c_idx_w'(1);
    endfunction

    stream_burst_arb_rr_sel #(
        .NUM_INP (NUM_INP),
        .IDX_W   (c_idx_w)
    ) u_rr_sel (
        .i_valid (inp_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_sel   (w_sel),
        .o_any   (w_any)
    );

    assign w_idx   = (r_state == LOCKED) ? r_lock_idx : w_sel;
    assign w_valid = ~flush_i & ((r_state == LOCKED) ? inp_valid_i[r_lock_idx] : w_any);
    // beat_cnt is always 0 in IDLE, so the cap test also covers MAX_BEATS == 1 there.
    assign w_end   = inp_last_i[w_idx] | (r_beat_cnt == c_cap);
    assign w_hs    = w_valid & oup_ready_i;

    assign oup_valid_o = w_valid;
    assign oup_data_o  = inp_data_i[w_idx];
    assign oup_last_o  = w_end;
    assign oup_idx_o   = w_idx;
    assign busy_o      = (r_state == LOCKED);

    for (genvar gi = 0; gi < NUM_INP; gi++) begin : g_ready
        assign inp_ready_o[gi] = w_hs & (w_idx == c_idx_w'(gi));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_beat_cnt <= '0;
        end else if (flush_i) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_hs && w_end) begin
                r_rr_ptr <= next_idx(w_sel);
            end else if (w_any) begin
                // Lock even when stalled so the presented beat cannot be re-arbitrated away.
                r_state    <= LOCKED;
                r_lock_idx <= w_sel;
                r_beat_cnt <= w_hs ? c_cnt_w'(1) : '0;
            end
        end else if (w_hs) begin
            if (w_end) begin
                r_state    <= IDLE;
                r_rr_ptr   <= next_idx(r_lock_idx);
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            end
        end
    end

`ifdef STREAM_BURST_ARB_TIMEOUT_EN
    localparam int c_tmo_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(TIMEOUT_CYCLES);

    logic [c_tmo_w-1:0] r_stall_cnt;
    logic               r_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else if (flush_i) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else if (r_state == LOCKED && !w_hs) begin
            if (r_stall_cnt != c_tmo_lim) begin
                r_stall_cnt <= r_stall_cnt + c_tmo_w'(1);
            end
            if (r_stall_cnt >= c_tmo_lim - c_tmo_w'(1)) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_tmo_cfg;
    assign w_unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_burst_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stream_burst_arbiter                                    |
// | Description : Directed plus random stimulus against a burst-owner model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_stream_burst_arbiter;

    localparam int NUM_INP        = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int MAX_BEATS      = 4;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int IDX_W          = 2;

    logic                               clk = 1'b0;
    logic                               rst_i = 1'b1;
    logic                               flush_i = 1'b0;
    logic [NUM_INP-1:0][DATA_WIDTH-1:0] inp_data_i;
    logic [NUM_INP-1:0]                 inp_last_i = '0;
    logic [NUM_INP-1:0]                 inp_valid_i = '0;
    logic [NUM_INP-1:0]                 inp_ready_o;
    logic [DATA_WIDTH-1:0]              oup_data_o;
    logic                               oup_last_o;
    logic                               oup_valid_o;
    logic                               oup_ready_i = 1'b0;
    logic [IDX_W-1:0]                   oup_idx_o;
    logic                               busy_o;
`ifdef STREAM_BURST_ARB_TIMEOUT_EN
    logic                               timeout_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int dir_idx  = -1;
    logic [NUM_INP-1:0] acc = '0;

    // Model: current burst owner (-1 when nobody holds the output).
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_stall = 0;
    bit m_tmo   = 1'b0;

    stream_burst_arbiter #(
        .NUM_INP        (NUM_INP),
        .DATA_WIDTH     (DATA_WIDTH),
        .MAX_BEATS      (MAX_BEATS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .inp_data_i  (inp_data_i),
        .inp_last_i  (inp_last_i),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (inp_ready_o),
        .oup_data_o  (oup_data_o),
        .oup_last_o  (oup_last_o),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .oup_idx_o   (oup_idx_o),
        .busy_o      (busy_o)
`ifdef STREAM_BURST_ARB_TIMEOUT_EN
        ,
        .timeout_o   (timeout_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_stall = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step();
        int                 own;
        int                 pick;
        bit                 e_valid;
        bit                 e_last;
        bit                 hs;
        bit                 held;
        logic [NUM_INP-1:0] e_ready;
        held = (m_owner >= 0);
        check("busy", busy_o, held);
        if (!held) begin
            pick = -1;
            for (int k = 0; k < NUM_INP; k++) begin
                if (pick < 0 && inp_valid_i[(m_ptr + k) % NUM_INP]) pick = (m_ptr + k) % NUM_INP;
            end
            own     = (pick < 0) ? 0 : pick;
            e_valid = (pick >= 0);
        end else begin
            own     = m_owner;
            e_valid = inp_valid_i[own];
        end
        e_last = inp_last_i[own] || (m_beats + 1 == MAX_BEATS);
        if (flush_i) e_valid = 1'b0;
        hs      = e_valid && oup_ready_i;
        e_ready = '0;
        if (hs) e_ready[own] = 1'b1;
        check("valid", oup_valid_o, e_valid);
        check("ready", inp_ready_o, e_ready);
        if (!flush_i) check("idx", oup_idx_o, own);
        if (e_valid) begin
            check("data", oup_data_o, inp_data_i[own]);
            check("last", oup_last_o, e_last);
        end
`ifdef STREAM_BURST_ARB_TIMEOUT_EN
        check("timeout", timeout_o, m_tmo);
        if (flush_i) begin
            m_stall = 0;
            m_tmo   = 1'b0;
        end else if (held && !hs) begin
            m_stall++;
            if (m_stall >= TIMEOUT_CYCLES) m_tmo = 1'b1;
        end else begin
            m_stall = 0;
        end
`endif
        if (flush_i) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
        end else if (hs && e_last) begin
            m_owner = -1;
            m_ptr   = (own + 1) % NUM_INP;
            m_beats = 0;
        end else if (hs) begin
            m_owner = own;
            m_beats++;
        end else if (e_valid || held) begin
            m_owner = own;
        end
    endtask

    task automatic cycle();
        #3;
        if (dir_idx >= 0) check("dir_idx", oup_idx_o, dir_idx);
        model_step();
        acc = inp_ready_o;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                        input logic fl, input int d);
        inp_valid_i = v;
        inp_last_i  = l;
        oup_ready_i = rdy;
        flush_i     = fl;
        dir_idx     = d;
        cycle();
    endtask

    // Protocol-abiding sources: a presented beat is held until it is accepted.
    task automatic refresh(input int pv, input int pl);
        for (int i = 0; i < NUM_INP; i++) begin
            if (!inp_valid_i[i] || acc[i]) begin
                inp_valid_i[i] = ($urandom_range(99) < pv);
                inp_last_i[i]  = ($urandom_range(99) < pl);
                inp_data_i[i]  = $urandom;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_INP; i++) inp_data_i[i] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", oup_valid_o, 1'b0);
        check("rst_ready", inp_ready_o, '0);
        check("rst_idx", oup_idx_o, '0);
        check("rst_busy", busy_o, 1'b0);
`ifdef STREAM_BURST_ARB_TIMEOUT_EN
        check("rst_timeout", timeout_o, 1'b0);
`endif
        rst_i = 1'b0;
        model_reset();

        // Single-beat bursts from everyone rotate the grant each cycle.
        step(4'hF, 4'hF, 1, 0, 0);
        step(4'hF, 4'hF, 1, 0, 1);
        step(4'hF, 4'hF, 1, 0, 2);
        step(4'hF, 4'hF, 1, 0, 3);
        step(4'hF, 4'hF, 1, 0, 0);
        // Req1 three-beat burst while req2 waits.
        step(4'b0110, 4'b0100, 1, 0, 1);
        step(4'b0110, 4'b0100, 1, 0, 1);
        step(4'b0110, 4'b0110, 1, 0, 1);
        step(4'b0100, 4'b0100, 1, 0, 2);
        // Req0 never asserts last: cap ends the grant after four beats.
        step(4'b0011, 4'b0010, 1, 0, 0);
        step(4'b0011, 4'b0010, 1, 0, 0);
        step(4'b0011, 4'b0010, 1, 0, 0);
        step(4'b0011, 4'b0010, 1, 0, 0);
        step(4'b0010, 4'b0010, 1, 0, 1);
        // Stall on req3; a later req0 request must not steal the grant.
        step(4'b1000, 4'b1000, 0, 0, 3);
        for (int n = 0; n < 4; n++) step(4'b1001, 4'b1001, 0, 0, 3);
        step(4'b1001, 4'b1001, 1, 0, 3);
        step(4'b0001, 4'b0001, 1, 0, 0);
        // Flush at beat 2 of a req2 burst, then req0 wins from pointer 0.
        step(4'b0101, 4'b0000, 1, 0, 2);
        step(4'b0101, 4'b0000, 1, 1, -1);
        step(4'b0101, 4'b0101, 1, 0, 0);
        // Long stall while locked, then flush.
        step(4'b0010, 4'b0000, 0, 0, 1);
        for (int n = 0; n < 10; n++) step(4'b0010, 4'b0000, 0, 0, 1);
        step(4'b0010, 4'b0000, 0, 1, -1);
        step(4'b0010, 4'b0010, 1, 0, 1);

        inp_valid_i = '0;
        inp_last_i  = '0;
        acc         = '0;
        dir_idx     = -1;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst_i = 1'b1;
                #2;
                check("midrst_busy", busy_o, 1'b0);
`ifdef STREAM_BURST_ARB_TIMEOUT_EN
                check("midrst_timeout", timeout_o, 1'b0);
`endif
                model_reset();
                @(posedge clk);
                #1;
                rst_i = 1'b0;
                acc   = '0;
            end
            refresh(60, 35);
            oup_ready_i = ($urandom_range(99) < 70);
            flush_i     = ($urandom_range(99) < 2);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
